// File: rtl/imem_loader_if.sv
// Stream and instruction-memory external-port signals shared by the loader and its environment.
// master: the loader side; slave: the stream source plus the memory responder.
interface imem_loader_if;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic [63:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [31:0] rdata_ext;

   modport master (
      input  s_valid, s_data, rdata_ext,
      output s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
   );

   modport slave (
      output s_valid, s_data, rdata_ext,
      input  s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
   );
endinterface

// File: rtl/imem_loader.sv
// Streams instruction words into IMEM through the external port, then enables the core.
// Define LOADER_VERIFY_EN to read the image back and compare checksums before enabling the core.
module imem_loader #(
   parameter int unsigned ADDR_W    = 9,
   parameter logic [63:0] BASE_ADDR = 64'h0
) (
   input  logic            clk,
   input  logic            arst,
   input  logic            start,
   input  logic            halt,
   input  logic [ADDR_W:0] num_words,
   imem_loader_if.master   bus,
   output logic            cpu_enable,
   output logic            busy,
   output logic            done,
   output logic            error,
   output logic [ADDR_W:0] words_loaded
);

   localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] CNT_ONE   = 1;

`ifdef LOADER_VERIFY_EN
   typedef enum logic [2:0] {StIdle, StLoad, StVerify, StRun, StErr} state_e;
`else
   typedef enum logic [2:0] {StIdle, StLoad, StRun, StErr} state_e;
`endif

   state_e          state_q, state_d;
   logic [ADDR_W:0] idx_q, idx_d;
   logic [ADDR_W:0] nw_q, nw_d;
   logic            wen_q, wen_d;
   logic [63:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            s_rdy;

`ifdef LOADER_VERIFY_EN
   logic            ren_q, ren_d;
   logic            pend_q;
   logic [31:0]     sum_q, sum_d;
   logic [31:0]     rsum_q, rsum_d;
   logic [ADDR_W:0] rd_idx_q, rd_idx_d;
   logic [ADDR_W:0] rcnt_q, rcnt_d;
`endif

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         nw_q     <= '0;
         wen_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
`ifdef LOADER_VERIFY_EN
         ren_q    <= 1'b0;
         pend_q   <= 1'b0;
         sum_q    <= '0;
         rsum_q   <= '0;
         rd_idx_q <= '0;
         rcnt_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         nw_q     <= nw_d;
         wen_q    <= wen_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
`ifdef LOADER_VERIFY_EN
         ren_q    <= ren_d;
         pend_q   <= ren_q;
         sum_q    <= sum_d;
         rsum_q   <= rsum_d;
         rd_idx_q <= rd_idx_d;
         rcnt_q   <= rcnt_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      nw_d     = nw_q;
      wen_d    = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      s_rdy    = 1'b0;
`ifdef LOADER_VERIFY_EN
      ren_d    = 1'b0;
      sum_d    = sum_q;
      rsum_d   = rsum_q;
      rd_idx_d = rd_idx_q;
      rcnt_d   = rcnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (num_words == '0 || num_words > MAX_WORDS) begin
                  state_d = StErr;
               end else begin
                  state_d = StLoad;
                  nw_d    = num_words;
                  idx_d   = '0;
`ifdef LOADER_VERIFY_EN
                  sum_d    = '0;
                  rsum_d   = '0;
                  rd_idx_d = '0;
                  rcnt_d   = '0;
`endif
               end
            end
         end
         StLoad: begin
            s_rdy = (idx_q < nw_q);
            if (s_rdy && bus.s_valid) begin
               wen_d   = 1'b1;
               addr_d  = BASE_ADDR + (64'(idx_q) << 2);
               wdata_d = bus.s_data;
               idx_d   = idx_q + CNT_ONE;
`ifdef LOADER_VERIFY_EN
               sum_d   = sum_q + bus.s_data;
`endif
            end
            // idx reaches nw only in the cycle carrying the final write
            if (idx_q == nw_q) begin
`ifdef LOADER_VERIFY_EN
               state_d = StVerify;
`else
               state_d = StRun;
`endif
            end
         end
`ifdef LOADER_VERIFY_EN
         StVerify: begin
            if (rd_idx_q < nw_q) begin
               ren_d    = 1'b1;
               addr_d   = BASE_ADDR + (64'(rd_idx_q) << 2);
               rd_idx_d = rd_idx_q + CNT_ONE;
            end
            // pend_q marks the cycle in which rdata_ext answers last cycle's read
            if (pend_q) begin
               rsum_d = rsum_q + bus.rdata_ext;
               rcnt_d = rcnt_q + CNT_ONE;
            end
            if (rcnt_q == nw_q) begin
               state_d = (rsum_q == sum_q) ? StRun : StErr;
            end
         end
`endif
         StRun: begin
            if (halt) state_d = StIdle;
         end
         StErr: begin
            if (halt) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.s_ready   = s_rdy;
   assign bus.wen_ext   = wen_q;
   assign bus.addr_ext  = addr_q;
   assign bus.wdata_ext = wdata_q;
   assign words_loaded  = idx_q;
   assign cpu_enable    = (state_q == StRun);
   assign done          = (state_q == StRun);
   assign error         = (state_q == StErr);

`ifdef LOADER_VERIFY_EN
   assign bus.ren_ext = ren_q;
   assign busy        = (state_q == StLoad) || (state_q == StVerify);
`else
   logic unused_rdata;
   assign unused_rdata = ^bus.rdata_ext;
   assign bus.ren_ext  = 1'b0;
   assign busy         = (state_q == StLoad);
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued per load, a negedge monitor checks them.
// Build with LOADER_VERIFY_EN defined to also exercise the readback/checksum path.
module tb_imem_loader;

   localparam int unsigned ADDR_W = 9;

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] data;
   } wr_t;

   logic            clk = 1'b0;
   logic            arst;
   logic            start;
   logic            halt;
   logic [ADDR_W:0] num_words;
   logic            cpu_enable;
   logic            busy;
   logic            done;
   logic            error;
   logic [ADDR_W:0] words_loaded;

   imem_loader_if bus ();

   imem_loader #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (64'h0)
   ) dut (
      .clk          (clk),
      .arst         (arst),
      .start        (start),
      .halt         (halt),
      .num_words    (num_words),
      .bus          (bus),
      .cpu_enable   (cpu_enable),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          ren_cnt  = 0;
   bit          prev_acc = 1'b0;
   bit          corrupt  = 1'b0;
   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [31:0] words[$];
   logic [31:0] mem [512];

`ifdef LOADER_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory responder: captures writes, answers reads one cycle later, optionally corrupting 0x8.
   always @(posedge clk) begin
      if (bus.wen_ext) mem[bus.addr_ext[10:2]] <= bus.wdata_ext;
      if (bus.ren_ext)
         bus.rdata_ext <= mem[bus.addr_ext[10:2]] ^
                          ((corrupt && bus.addr_ext == 64'h8) ? 32'h1 : 32'h0);
   end

   // Monitor: every write must follow an accepted beat and match the head of the scoreboard.
   always @(negedge clk) begin
      if (arst) begin
         prev_acc = 1'b0;
      end else begin
         if (bus.wen_ext && bus.ren_ext) check("wen_ren_exclusive", 1, 0);
         if (bus.wen_ext || prev_acc) check("wen_after_accept", bus.wen_ext, prev_acc);
         if (bus.wen_ext) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", bus.addr_ext, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               mon_e = exp_q.pop_front();
               check("write_addr", bus.addr_ext, mon_e.addr);
               check("write_data", bus.wdata_ext, mon_e.data);
            end
         end
         if (bus.ren_ext) ren_cnt++;
         prev_acc = bus.s_valid && bus.s_ready;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input bit st, input bit hl);
      start = st;
      halt  = hl;
      step();
      start = 1'b0;
      halt  = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctrl"}, {cpu_enable, busy, done, error, bus.s_ready, bus.wen_ext,
                             bus.ren_ext}, 0);
      check({tag, "_words_loaded"}, words_loaded, 0);
      check({tag, "_addr"}, bus.addr_ext, 0);
      check({tag, "_wdata"}, bus.wdata_ext, 0);
   endtask

   task automatic send_word(input logic [31:0] w, input bit bubble, input bit halt_bubble);
      bit acc = 1'b0;
      if (bubble) begin
         bus.s_valid = 1'b0;
         halt = halt_bubble;
         step();
         halt = 1'b0;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = w;
      for (int k = 0; k < 32 && !acc; k++) begin
         @(negedge clk);
         acc = bus.s_ready;
         step();
      end
      check("stream_accept", acc, 1);
      bus.s_valid = 1'b0;
   endtask

   // bubble_mode: 0 back-to-back, 1 alternating bubbles, 2 random bubbles
   task automatic do_load(input int bubble_mode, input bit halt_mid, input bit corrupt_rd,
                          input bit halt_with_start);
      int n = words.size();
      int limit;
      bit exp_err;
      bit bub;
      corrupt = corrupt_rd;
      for (int i = 0; i < n; i++) exp_q.push_back({64'(4 * i), words[i]});
      ren_cnt   = 0;
      num_words = (ADDR_W + 1)'(n);
      pulse(1'b1, halt_with_start);
      @(negedge clk);
      check("load_busy", busy, 1);
      check("load_s_ready", bus.s_ready, 1);
      step();
      for (int i = 0; i < n; i++) begin
         bub = (bubble_mode == 1) ? (i % 2 == 1) :
               (bubble_mode == 2) ? bit'($urandom_range(0, 1)) : 1'b0;
         send_word(words[i], bub || (halt_mid && i == n / 2), halt_mid && i == n / 2);
      end
      @(negedge clk);
      limit = VERIFY ? 4 * n + 8 : 2;
      for (int k = 0; k < limit && !(cpu_enable || error); k++) @(negedge clk);
      exp_err = VERIFY && corrupt_rd && n > 2;
      check("cpu_enable", cpu_enable, !exp_err);
      check("done", done, !exp_err);
      check("error", error, exp_err);
      check("busy_after", busy, 0);
      check("words_loaded", words_loaded, n);
      check("writes_outstanding", exp_q.size(), 0);
      check("ren_pulses", ren_cnt, VERIFY ? n : 0);
      step();
      corrupt = 1'b0;
   endtask

   task automatic go_idle();
      pulse(1'b0, 1'b1);
      @(negedge clk);
      check("idle_ctrl", {cpu_enable, done, error, busy}, 0);
      step();
   endtask

   task automatic bad_start(input logic [ADDR_W:0] n);
      num_words = n;
      pulse(1'b1, 1'b0);
      @(negedge clk);
      check("bad_start_error", error, 1);
      check("bad_start_ctrl", {busy, cpu_enable, done}, 0);
      step();
      num_words = 4;
      pulse(1'b1, 1'b0);
      @(negedge clk);
      check("err_ignores_start", {error, busy}, 2'b10);
      step();
      go_idle();
   endtask

   initial begin
      arst        = 1'b1;
      start       = 1'b0;
      halt        = 1'b0;
      num_words   = '0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      #12;
      check_zero("reset");
      @(negedge clk);
      #2 arst = 1'b0;
      step();

      // Back-to-back four-word program
      words = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h002081B3};
      do_load(0, 1'b0, 1'b0, 1'b0);

      // In RUN: start is ignored, start+halt lets halt win
      num_words = 7;
      pulse(1'b1, 1'b0);
      @(negedge clk);
      check("run_ignores_start", {done, cpu_enable, busy}, 3'b110);
      check("run_words_kept", words_loaded, 4);
      step();
      pulse(1'b1, 1'b1);
      @(negedge clk);
      check("halt_wins_in_run", {cpu_enable, done, busy}, 0);
      step();

      // Alternating bubbles, started with start+halt in IDLE (start wins)
      do_load(1, 1'b0, 1'b0, 1'b1);
      go_idle();

      // Illegal lengths
      bad_start(0);
      bad_start(513);

      // Reset after two accepted words, then a one-word load
      exp_q.push_back({64'h0, words[0]});
      num_words = 4;
      pulse(1'b1, 1'b0);
      send_word(words[0], 1'b0, 1'b0);
      send_word(words[1], 1'b0, 1'b0);
      arst = 1'b1;
      #1;
      check_zero("midload_reset");
      exp_q.delete();
      @(negedge clk);
      #2 arst = 1'b0;
      step();
      words = '{32'h00500293};
      do_load(0, 1'b0, 1'b0, 1'b0);
      go_idle();

      // Random lengths, data and bubbles, with halt pulsed mid-load
      for (int t = 0; t < 6; t++) begin
         words.delete();
         for (int i = 0; i < int'($urandom_range(1, 24)); i++) words.push_back($urandom);
         do_load(2, bit'(t % 2), 1'b0, 1'b0);
         go_idle();
      end

      // Full capacity
      words.delete();
      for (int i = 0; i < 512; i++) words.push_back($urandom);
      do_load(0, 1'b0, 1'b0, 1'b0);
      go_idle();

`ifdef LOADER_VERIFY_EN
      // Readback of 0x8 corrupted, then clean
      words = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h002081B3};
      do_load(0, 1'b0, 1'b1, 1'b0);
      go_idle();
      do_load(2, 1'b0, 1'b0, 1'b0);
      go_idle();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
